// File: rtl/mem_access.sv
// Memory-access stage: turns ALU load/store requests into a data-memory
// req/gnt/rvalid handshake and produces one registered write-back beat.
module mem_access #(
    parameter int cDataWidth    = 32,
    parameter int cRegAddrWidth = 5,
    parameter int cTimeout      = 15
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iMemRead,
    input  logic                     iMemWrite,
    input  logic [cDataWidth-1:0]    iMemAddr,
    input  logic [cDataWidth-1:0]    iMemData,
    input  logic [2:0]               iMemOpType,
    input  logic [cRegAddrWidth-1:0] iRdAddr,
    input  logic                     iRegDv,
    input  logic [cRegAddrWidth-1:0] iRegAddr,
    input  logic [cDataWidth-1:0]    iRegData,
    output logic                     oStall,
    output logic                     oDmemReq,
    output logic                     oDmemWe,
    output logic [cDataWidth-1:0]    oDmemAddr,
    output logic [cDataWidth-1:0]    oDmemWdata,
    output logic [3:0]               oDmemBe,
    input  logic                     iDmemGnt,
    input  logic                     iDmemRvalid,
    input  logic [cDataWidth-1:0]    iDmemRdata,
    output logic                     oWbDv,
    output logic [cRegAddrWidth-1:0] oWbAddr,
    output logic [cDataWidth-1:0]    oWbData,
    output logic                     oMisalign,
    output logic                     oIllegal,
    output logic                     oBusErr
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RD = 2'd2} stateT;

    localparam int cCntWidth = $clog2(cTimeout + 1);

    stateT                     state;
    stateT                     nextState;
    logic [cCntWidth-1:0]      waitCnt;
    logic [2:0]                opTypeQ;
    logic [1:0]                addrLowQ;
    logic [cRegAddrWidth-1:0]  rdAddrQ;
    logic                      reqBoth;
    logic                      reqAny;
    logic                      opLegal;
    logic                      misaligned;
    logic                      accept;
    logic                      timeout;
    logic [3:0]                storeBe;
    logic [cDataWidth-1:0]     storeWdata;
    logic [cDataWidth-1:0]     laneData;
    logic [cDataWidth-1:0]     loadData;

    // Request decode; only meaningful while IDLE, when inputs are sampled.
    always_comb begin
        reqBoth = iMemRead & iMemWrite;
        reqAny  = iMemRead | iMemWrite;
        opLegal = 1'b0;
        if (iMemRead) begin
            case (iMemOpType)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: opLegal = 1'b1;
                default:                                opLegal = 1'b0;
            endcase
        end else if (iMemWrite) begin
            case (iMemOpType)
                3'b000, 3'b001, 3'b010: opLegal = 1'b1;
                default:                opLegal = 1'b0;
            endcase
        end
        misaligned = ((iMemOpType[1:0] == 2'b01) && iMemAddr[0]) ||
                     ((iMemOpType[1:0] == 2'b10) && (iMemAddr[1:0] != 2'b00));
        accept     = reqAny & ~reqBoth & opLegal & ~misaligned;
        storeBe    = 4'hF;
        storeWdata = iMemData;
        case (iMemOpType[1:0])
            2'b00: begin
                storeBe    = 4'b0001 << iMemAddr[1:0];
                storeWdata = {4{iMemData[7:0]}};
            end
            2'b01: begin
                storeBe    = 4'b0011 << iMemAddr[1:0];
                storeWdata = {2{iMemData[15:0]}};
            end
            default: ;
        endcase
        if (iMemRead) begin
            storeBe = 4'hF;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        timeout   = (waitCnt == cCntWidth'(cTimeout - 1));
        case (state)
            IDLE: begin
                if (accept) nextState = REQ;
            end
            REQ: begin
                if (iDmemGnt)     nextState = oDmemWe ? IDLE : WAIT_RD;
                else if (timeout) nextState = IDLE;
            end
            WAIT_RD: begin
                if (iDmemRvalid || timeout) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        oStall   = (state != IDLE);
        oDmemReq = (state == REQ);
        laneData = iDmemRdata >> {addrLowQ, 3'b000};
        case (opTypeQ)
            3'b000:  loadData = {{24{laneData[7]}}, laneData[7:0]};
            3'b001:  loadData = {{16{laneData[15]}}, laneData[15:0]};
            3'b100:  loadData = {24'd0, laneData[7:0]};
            3'b101:  loadData = {16'd0, laneData[15:0]};
            default: loadData = iDmemRdata;
        endcase
    end

    // Wait counter restarts whenever a new state is entered.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            waitCnt <= '0;
        end else if (nextState != state) begin
            waitCnt <= '0;
        end else if (state != IDLE) begin
            waitCnt <= waitCnt + cCntWidth'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDmemWe    <= 1'b0;
            oDmemAddr  <= '0;
            oDmemWdata <= '0;
            oDmemBe    <= 4'h0;
            opTypeQ    <= 3'b000;
            addrLowQ   <= 2'b00;
            rdAddrQ    <= '0;
            oWbDv      <= 1'b0;
            oWbAddr    <= '0;
            oWbData    <= '0;
            oMisalign  <= 1'b0;
            oIllegal   <= 1'b0;
            oBusErr    <= 1'b0;
        end else begin
            oWbDv     <= 1'b0;
            oMisalign <= 1'b0;
            oIllegal  <= 1'b0;
            oBusErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqBoth || (reqAny && !opLegal)) begin
                        oIllegal <= 1'b1;
                    end else if (reqAny && misaligned) begin
                        oMisalign <= 1'b1;
                    end else if (reqAny) begin
                        oDmemWe    <= iMemWrite;
                        oDmemAddr  <= {iMemAddr[cDataWidth-1:2], 2'b00};
                        oDmemWdata <= iMemWrite ? storeWdata : '0;
                        oDmemBe    <= storeBe;
                        opTypeQ    <= iMemOpType;
                        addrLowQ   <= iMemAddr[1:0];
                        rdAddrQ    <= iRdAddr;
                    end else if (iRegDv) begin
                        oWbDv   <= 1'b1;
                        oWbAddr <= iRegAddr;
                        oWbData <= iRegData;
                    end
                end
                REQ: begin
                    if (!iDmemGnt && timeout) oBusErr <= 1'b1;
                end
                WAIT_RD: begin
                    if (iDmemRvalid) begin
                        if (rdAddrQ != '0) begin
                            oWbDv   <= 1'b1;
                            oWbAddr <= rdAddrQ;
                            oWbData <= loadData;
                        end
                    end else if (timeout) begin
                        oBusErr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a memory responder drives the handshake,
// a spec-level model predicts every bus request, write-back and error pulse.
module tb_mem_access;

    localparam int cTimeout = 15;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iMemRead, iMemWrite, iRegDv;
    logic [31:0] iMemAddr, iMemData, iRegData;
    logic [2:0]  iMemOpType;
    logic [4:0]  iRdAddr, iRegAddr;
    logic        oStall, oDmemReq, oDmemWe;
    logic [31:0] oDmemAddr, oDmemWdata;
    logic [3:0]  oDmemBe;
    logic        iDmemGnt, iDmemRvalid;
    logic [31:0] iDmemRdata;
    logic        oWbDv;
    logic [4:0]  oWbAddr;
    logic [31:0] oWbData;
    logic        oMisalign, oIllegal, oBusErr;

    mem_access #(.cDataWidth(32), .cRegAddrWidth(5), .cTimeout(cTimeout)) dut (
        .iClk(iClk), .iRst(iRst),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemAddr(iMemAddr),
        .iMemData(iMemData), .iMemOpType(iMemOpType), .iRdAddr(iRdAddr),
        .iRegDv(iRegDv), .iRegAddr(iRegAddr), .iRegData(iRegData),
        .oStall(oStall), .oDmemReq(oDmemReq), .oDmemWe(oDmemWe),
        .oDmemAddr(oDmemAddr), .oDmemWdata(oDmemWdata), .oDmemBe(oDmemBe),
        .iDmemGnt(iDmemGnt), .iDmemRvalid(iDmemRvalid), .iDmemRdata(iDmemRdata),
        .oWbDv(oWbDv), .oWbAddr(oWbAddr), .oWbData(oWbData),
        .oMisalign(oMisalign), .oIllegal(oIllegal), .oBusErr(oBusErr)
    );

    always #5 iClk = ~iClk;

    typedef enum int {kWb, kStore, kLdReq, kMis, kIll, kBus} kindT;
    typedef struct {
        kindT        kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [4:0]  regIdx;
        int          cyc;
    } expT;

    expT         expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    logic [31:0] refMem [256];
    logic [31:0] busMem [256];
    int          gntDelay = 0;
    int          rdDelay = 0;
    bit          noRvalid = 1'b0;

    int          reqCnt = 0, rdCnt = 0, stallRun = 0;
    bit          pending = 1'b0, gntLast = 1'b0, gntLoad = 1'b0, rvLast = 1'b0;
    logic        heldWe;
    logic [31:0] heldAddr, heldWdata;
    logic [3:0]  heldBe;

    always @(posedge iClk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic void pushExp(input kindT k, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] b, input logic [4:0] r, input int c);
        expT e;
        e.kind = k; e.addr = a; e.data = d; e.be = b; e.regIdx = r; e.cyc = c;
        expQ.push_back(e);
    endfunction

    // Reference model: what the stage must do with one sampled request.
    function automatic void modelIssue(input logic rd, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [2:0] op,
                                       input logic [4:0] rdA, input logic regDv,
                                       input logic [4:0] regA, input logic [31:0] regD, input int k);
        bit          legal;
        int          size, sh;
        logic [31:0] word, val, mask, wd;
        logic [3:0]  be;
        if (rd && wr) begin
            pushExp(kIll, 0, 0, 0, 0, k + 1);
        end else if (rd || wr) begin
            legal = rd ? (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (op inside {3'd0, 3'd1, 3'd2});
            size  = 1 << op[1:0];
            if (!legal) begin
                pushExp(kIll, 0, 0, 0, 0, k + 1);
            end else if ((addr % size) != 0) begin
                pushExp(kMis, 0, 0, 0, 0, k + 1);
            end else if (rd) begin
                pushExp(kLdReq, {addr[31:2], 2'b00}, 0, 4'hF, 0, k + 1 + gntDelay);
                word = refMem[addr[9:2]];
                sh   = 8 * int'(addr % 4);
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                val  = (word >> sh) & mask;
                if (!op[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
                if (noRvalid)       pushExp(kBus, 0, 0, 0, 0, -1);
                else if (rdA != 0)  pushExp(kWb, 0, val, 0, rdA, k + 3 + gntDelay + rdDelay);
            end else begin
                be = 4'(((1 << size) - 1) << (addr % 4));
                wd = (size == 1) ? {4{data[7:0]}} : (size == 2) ? {2{data[15:0]}} : data;
                pushExp(kStore, {addr[31:2], 2'b00}, wd, be, 0, k + 1 + gntDelay);
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[addr[9:2]][8 * b +: 8] = wd[8 * b +: 8];
            end
        end else if (regDv) begin
            pushExp(kWb, 0, regD, 0, regA, k + 1);
        end
    endfunction

    task automatic popCheck(input kindT k, input string name);
        expT e;
        if (expQ.size() == 0) begin
            checkOutput({"unexpected_", name}, 1, 0);
            return;
        end
        e = expQ.pop_front();
        checkOutput({name, "_kind"}, k, e.kind);
        if (e.kind != k) return;
        if (e.cyc >= 0) checkOutput({name, "_cycle"}, cycle, e.cyc);
        case (k)
            kWb: begin
                checkOutput("wbAddr", oWbAddr, e.regIdx);
                checkOutput("wbData", oWbData, e.data);
            end
            kStore, kLdReq: begin
                checkOutput({name, "_addr"}, oDmemAddr, e.addr);
                checkOutput({name, "_be"}, oDmemBe, e.be);
                if (k == kStore) checkOutput("storeWdata", oDmemWdata, e.data);
            end
            default: ;
        endcase
    endtask

    // Output monitor: write-back and error pulses.
    always @(negedge iClk) begin
        int act;
        if (!iRst) begin
            act = int'(oWbDv) + int'(oMisalign) + int'(oIllegal) + int'(oBusErr);
            if (act > 0) checkOutput("singlePulse", act, 1);
            if (oWbDv)     popCheck(kWb, "wb");
            if (oMisalign) popCheck(kMis, "misalign");
            if (oIllegal)  popCheck(kIll, "illegal");
            if (oBusErr)   popCheck(kBus, "busErr");
        end
    end

    // Memory responder: grants, read data, ignored noise, bus stability checks.
    always @(negedge iClk) begin
        if (iRst) begin
            iDmemGnt = 0; iDmemRvalid = 0; pending = 0; gntLast = 0; rvLast = 0;
            reqCnt = 0; rdCnt = 0; stallRun = 0;
        end else begin
            stallRun = oStall ? stallRun + 1 : 0;
            if (oBusErr) checkOutput("busErrWait", rdCnt, cTimeout);
            if (gntLast) begin
                gntLast = 0; pending = gntLoad; rdCnt = 0;
                if (!gntLoad) checkOutput("stallDropAfterStore", oStall, 0);
            end
            if (rvLast) begin rvLast = 0; pending = 0; end
            if (pending && !oStall) pending = 0;
            iDmemGnt = 0; iDmemRvalid = 0; iDmemRdata = $urandom;
            if (oDmemReq) begin
                if (reqCnt > 0) checkOutput("reqStable", {oDmemWe, oDmemAddr[30:0]} ^ oDmemWdata ^ {28'd0, oDmemBe},
                                            {heldWe, heldAddr[30:0]} ^ heldWdata ^ {28'd0, heldBe});
                heldWe = oDmemWe; heldAddr = oDmemAddr; heldWdata = oDmemWdata; heldBe = oDmemBe;
                if (reqCnt == gntDelay) begin
                    iDmemGnt = 1; gntLast = 1; gntLoad = !oDmemWe;
                    popCheck(oDmemWe ? kStore : kLdReq, oDmemWe ? "store" : "loadReq");
                    if (oDmemWe) begin
                        checkOutput("storeStallCycles", stallRun, gntDelay + 1);
                        for (int b = 0; b < 4; b++)
                            if (oDmemBe[b]) busMem[oDmemAddr[9:2]][8 * b +: 8] = oDmemWdata[8 * b +: 8];
                    end
                end
                reqCnt++;
            end else begin
                reqCnt = 0;
                if (pending) begin
                    if (!noRvalid && rdCnt == rdDelay) begin
                        iDmemRvalid = 1; iDmemRdata = busMem[heldAddr[9:2]]; rvLast = 1;
                    end
                    rdCnt++;
                end else begin
                    iDmemGnt    = ($urandom_range(0, 4) == 0);
                    iDmemRvalid = ($urandom_range(0, 4) == 0);
                end
            end
        end
    end

    task automatic clearInputs();
        iMemRead = 0; iMemWrite = 0; iRegDv = 0;
        iMemAddr = $urandom; iMemData = $urandom; iMemOpType = 3'($urandom);
        iRdAddr = 5'($urandom); iRegAddr = 5'($urandom); iRegData = $urandom;
    endtask

    // Present one request, hold it until the stage can sample it, then release.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [2:0] op, input logic [4:0] rdA,
                                 input logic regDv, input logic [4:0] regA, input logic [31:0] regD,
                                 input int g, input int r, input bit nrv);
        int waited = 0;
        iMemRead = rd; iMemWrite = wr; iMemAddr = addr; iMemData = data; iMemOpType = op;
        iRdAddr = rdA; iRegDv = regDv; iRegAddr = regA; iRegData = regD;
        @(negedge iClk);
        while (oStall && waited < 200) begin
            @(negedge iClk);
            waited++;
        end
        if (oStall) checkOutput("stallBound", oStall, 0);
        gntDelay = g; rdDelay = r; noRvalid = nrv;
        modelIssue(rd, wr, addr, data, op, rdA, regDv, regA, regD, cycle);
        @(posedge iClk);
        #1;
        clearInputs();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_stall"}, oStall, 0);
        checkOutput({tag, "_req"}, oDmemReq, 0);
        checkOutput({tag, "_we"}, oDmemWe, 0);
        checkOutput({tag, "_addr"}, oDmemAddr, 0);
        checkOutput({tag, "_wdata"}, oDmemWdata, 0);
        checkOutput({tag, "_be"}, oDmemBe, 0);
        checkOutput({tag, "_wbDv"}, oWbDv, 0);
        checkOutput({tag, "_wbAddr"}, oWbAddr, 0);
        checkOutput({tag, "_wbData"}, oWbData, 0);
        checkOutput({tag, "_errs"}, {oMisalign, oIllegal, oBusErr}, 0);
    endtask

    initial begin
        int waited;
        int kind;
        iRst = 1; iDmemGnt = 0; iDmemRvalid = 0; iDmemRdata = 0;
        clearInputs();
        for (int i = 0; i < 256; i++) begin
            refMem[i] = $urandom;
            busMem[i] = refMem[i];
        end
        refMem[8'h40] = 32'h80FF_1234;
        busMem[8'h40] = 32'h80FF_1234;
        repeat (2) @(posedge iClk);
        #1;
        checkResetOutputs("reset");
        iRst = 0;
        @(posedge iClk);
        #1;

        $display("[TB] directed loads");
        applyStimulus(1, 0, 32'h103, 0, 3'b000, 5'd1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h103, 0, 3'b100, 5'd2, 0, 0, 0, 1, 2, 0);
        applyStimulus(1, 0, 32'h102, 0, 3'b001, 5'd3, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h102, 0, 3'b101, 5'd4, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed stores");
        applyStimulus(0, 1, 32'h202, 32'h1234_56AB, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h206, 32'hCAFE_BEEF, 3'b001, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 32'h208, 32'hDEAD_0123, 3'b010, 0, 0, 0, 0, 3, 0, 0);
        applyStimulus(1, 0, 32'h200, 0, 3'b010, 5'd5, 0, 0, 0, 0, 0, 0);

        $display("[TB] error cases");
        applyStimulus(1, 0, 32'h101, 0, 3'b010, 5'd6, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h100, 0, 3'b011, 5'd6, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h100, 0, 3'b010, 5'd6, 1, 5'd9, 32'h99, 0, 0, 0);
        applyStimulus(1, 0, 32'h104, 0, 3'b010, 5'd7, 0, 0, 0, 0, 0, 1);

        $display("[TB] reset during read wait");
        applyStimulus(1, 0, 32'h108, 0, 3'b010, 5'd8, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge iClk);
        #2;
        iRst = 1;
        #1;
        checkResetOutputs("midReset");
        expQ.delete();
        @(negedge iClk);
        @(posedge iClk);
        #1;
        iRst = 0;
        applyStimulus(1, 0, 32'h108, 0, 3'b010, 5'd8, 0, 0, 0, 0, 0, 0);

        $display("[TB] throughput");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'd1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd6, 32'd2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'd3, 0, 0, 0);
        applyStimulus(1, 0, 32'h10C, 0, 3'b010, 5'd0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h55, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3)
                applyStimulus(0, 0, $urandom, $urandom, 3'($urandom), 5'($urandom), 1,
                              5'($urandom), $urandom, 0, 0, 0);
            else
                applyStimulus(kind < 6 || kind == 9, kind >= 6, 32'h100 + $urandom_range(0, 767),
                              $urandom, (kind < 6) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3)),
                              5'($urandom), 1'($urandom), 5'($urandom), $urandom,
                              $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        waited = 0;
        while ((expQ.size() != 0 || oStall) && waited < 200) begin
            @(negedge iClk);
            waited++;
        end
        repeat (3) @(negedge iClk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
